label_stats: RTL and testbench



---
 rtl/label_stats_pkg.sv | 22 ++
 rtl/label_stats_bbox_merge.sv | 41 ++++
 rtl/label_stats.sv | 120 ++++++++++++
 tb/tb_label_stats.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/label_stats_pkg.sv
// Shared widths, FSM state and table record for the label statistics block.
// Record fields are sized for the default widths; narrower parameters saturate inside them.
package label_stats_pkg;

    localparam int DEF_LABEL_W = 8;
    localparam int DEF_COORD_W = 10;
    localparam int DEF_COUNT_W = 20;

    typedef enum logic {
        ACCUM,
        DUMP
    } state_t;

    typedef struct packed {
        logic [DEF_COORD_W-1:0] min_x;
        logic [DEF_COORD_W-1:0] max_x;
        logic [DEF_COORD_W-1:0] min_y;
        logic [DEF_COORD_W-1:0] max_y;
        logic [DEF_COUNT_W-1:0] count;
    } entry_t;

endpackage

// File: rtl/label_stats_bbox_merge.sv
// Merges one pixel at (x,y) into a label's bounding box / pixel count.
// Purely combinational; no backpressure.
// First pixel seeds the box; later pixels widen it and bump a saturating count.
module bbox_merge
    import label_stats_pkg::*;
#(
    parameter int COORD_W = DEF_COORD_W,
    parameter int COUNT_W = DEF_COUNT_W
) (
    input  entry_t             old_entry,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    output entry_t             new_entry
);

    localparam logic [DEF_COUNT_W-1:0] COUNT_MAX = DEF_COUNT_W'((64'd1 << COUNT_W) - 64'd1);

    logic [DEF_COORD_W-1:0] xe;
    logic [DEF_COORD_W-1:0] ye;

    assign xe = DEF_COORD_W'(x);
    assign ye = DEF_COORD_W'(y);

    always_comb begin
        new_entry = old_entry;
        if (old_entry.count == '0) begin
            new_entry.min_x = xe;
            new_entry.max_x = xe;
            new_entry.min_y = ye;
            new_entry.max_y = ye;
            new_entry.count = DEF_COUNT_W'(1);
        end else begin
            if (xe < old_entry.min_x) new_entry.min_x = xe;
            if (xe > old_entry.max_x) new_entry.max_x = xe;
            if (ye < old_entry.min_y) new_entry.min_y = ye;
            if (ye > old_entry.max_y) new_entry.max_y = ye;
            if (old_entry.count != COUNT_MAX) new_entry.count = old_entry.count + 1'b1;
        end
    end

endmodule

// File: rtl/label_stats.sv
// Per-label bounding box and pixel count over a frame, dumped as records after vsync.
// Pixel update visible next cycle; dump takes 2^LABEL_W-1 cycles plus stalls.
// Records hold on out_valid until out_ready; pixels arriving during the dump are dropped.
module label_stats
    import label_stats_pkg::*;
#(
    parameter int LABEL_W = DEF_LABEL_W,
    parameter int COORD_W = DEF_COORD_W,
    parameter int COUNT_W = DEF_COUNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               hsync,
    input  logic               vsync,
    input  logic [LABEL_W-1:0] label,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LABEL_W-1:0] out_label,
    output logic [COORD_W-1:0] out_min_x,
    output logic [COORD_W-1:0] out_max_x,
    output logic [COORD_W-1:0] out_min_y,
    output logic [COORD_W-1:0] out_max_y,
    output logic [COUNT_W-1:0] out_count,
    output logic               busy,
    output logic               dropped,
    output logic               frame_done
);

    localparam int N = 1 << LABEL_W;
    localparam logic [COORD_W-1:0] COORD_MAX = '1;

    state_t             state;
    state_t             state_nxt;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [LABEL_W-1:0] idx;
    entry_t             tbl_q [N];
    entry_t             cur;
    entry_t             merged;
    logic               pix_accum;
    logic               rec_vld;
    logic               clear_cur;
    logic               last_idx;

    bbox_merge #(
        .COORD_W (COORD_W),
        .COUNT_W (COUNT_W)
    ) u_merge (
        .old_entry (tbl_q[label]),
        .x         (x),
        .y         (y),
        .new_entry (merged)
    );

    assign cur       = tbl_q[idx];
    assign pix_accum = (state == ACCUM) && en && !hsync && !vsync && (label != '0);
    assign rec_vld   = (state == DUMP) && (cur.count != '0);
    // Empty entries retire unconditionally; populated ones wait for the consumer.
    assign clear_cur = (state == DUMP) && ((cur.count == '0) || out_ready);
    assign last_idx  = (idx == '1);

    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM:   if (vsync) state_nxt = DUMP;
            DUMP:    if (clear_cur && last_idx) state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ACCUM;
            idx        <= LABEL_W'(1);
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            frame_done <= (state == DUMP) && (state_nxt == ACCUM);
            if (state == ACCUM) idx <= LABEL_W'(1);
            else if (clear_cur) idx <= idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x <= '0;
            y <= '0;
        end else if (vsync) begin
            x <= '0;
            y <= '0;
        end else if (hsync) begin
            x <= '0;
            if (y != COORD_MAX) y <= y + 1'b1;
        end else if (en && (x != COORD_MAX)) begin
            x <= x + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) tbl_q[i] <= '0;
        end else if (pix_accum) begin
            tbl_q[label] <= merged;
        end else if (clear_cur) begin
            tbl_q[idx] <= '0;
        end
    end

    assign busy      = (state == DUMP);
    assign dropped   = (state == DUMP) && en && (label != '0);
    assign out_valid = rec_vld;
    assign out_label = rec_vld ? idx : '0;
    assign out_min_x = rec_vld ? cur.min_x[COORD_W-1:0] : '0;
    assign out_max_x = rec_vld ? cur.max_x[COORD_W-1:0] : '0;
    assign out_min_y = rec_vld ? cur.min_y[COORD_W-1:0] : '0;
    assign out_max_y = rec_vld ? cur.max_y[COORD_W-1:0] : '0;
    assign out_count = rec_vld ? cur.count[COUNT_W-1:0] : '0;

endmodule

// File: tb/tb_label_stats.sv
// Scoreboarded bench for label_stats: reference model from pixel lists, monitor on valid/ready.
module tb_label_stats;

    localparam int XY_MAX = 1023;
    localparam int CNT_MAX = (1 << 20) - 1;

    logic        clk = 1'b0;
    logic        reset, en, hsync, vsync, out_ready;
    logic [7:0]  label, out_label;
    logic [9:0]  out_min_x, out_max_x, out_min_y, out_max_y;
    logic [19:0] out_count;
    logic        out_valid, busy, dropped, frame_done;

    logic        s_en, s_vsync;
    logic [1:0]  s_label, s_out_label;
    logic [9:0]  s_min_x, s_max_x, s_min_y, s_max_y;
    logic [3:0]  s_count;
    logic        s_valid, s_busy, s_dropped, s_done;

    label_stats dut (
        .clk(clk), .reset(reset), .en(en), .hsync(hsync), .vsync(vsync), .label(label),
        .out_valid(out_valid), .out_ready(out_ready), .out_label(out_label),
        .out_min_x(out_min_x), .out_max_x(out_max_x), .out_min_y(out_min_y), .out_max_y(out_max_y),
        .out_count(out_count), .busy(busy), .dropped(dropped), .frame_done(frame_done)
    );

    label_stats #(.LABEL_W(2), .COORD_W(10), .COUNT_W(4)) dut_small (
        .clk(clk), .reset(reset), .en(s_en), .hsync(1'b0), .vsync(s_vsync), .label(s_label),
        .out_valid(s_valid), .out_ready(1'b1), .out_label(s_out_label),
        .out_min_x(s_min_x), .out_max_x(s_max_x), .out_min_y(s_min_y), .out_max_y(s_max_y),
        .out_count(s_count), .busy(s_busy), .dropped(s_dropped), .frame_done(s_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit done;
        int lab, mnx, mxx, mny, mxy, cnt;
    } exp_t;
    typedef struct {
        int x, y, lab;
    } px_t;

    exp_t exp_q[$];
    px_t  frame_px[$];
    int   checks = 0, failures = 0;
    int   mx = 0, my = 0;
    bit   in_dump = 0;
    int   cyc_cnt = 0, vs_cyc = 0, done_cyc = 0;
    int   rdy_mode = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at cycle %0d", name, act, exp, cyc_cnt);
        end
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: every presented record must match the scoreboard head; pop on acceptance.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid) begin
                if (exp_q.size() == 0 || exp_q[0].done) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_record got label=%0d exp=none", out_label);
                end else begin
                    chk("rec_label", out_label, exp_q[0].lab);
                    chk("rec_min_x", out_min_x, exp_q[0].mnx);
                    chk("rec_max_x", out_max_x, exp_q[0].mxx);
                    chk("rec_min_y", out_min_y, exp_q[0].mny);
                    chk("rec_max_y", out_max_y, exp_q[0].mxy);
                    chk("rec_count", out_count, exp_q[0].cnt);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (frame_done) begin
                if (exp_q.size() == 0 || !exp_q[0].done) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_frame_done got=1 exp=0 pending=%0d", exp_q.size());
                end else begin
                    chk("frame_done", frame_done, 1);
                    void'(exp_q.pop_front());
                    done_cyc = cyc_cnt;
                end
            end
        end
    end

    task automatic build_expected();
        for (int l = 1; l < 256; l++) begin
            exp_t r;
            int   n;
            n = 0;
            r.done = 0; r.lab = l;
            r.mnx = XY_MAX + 1; r.mxx = -1; r.mny = XY_MAX + 1; r.mxy = -1;
            foreach (frame_px[i]) begin
                if (frame_px[i].lab == l) begin
                    n++;
                    if (frame_px[i].x < r.mnx) r.mnx = frame_px[i].x;
                    if (frame_px[i].x > r.mxx) r.mxx = frame_px[i].x;
                    if (frame_px[i].y < r.mny) r.mny = frame_px[i].y;
                    if (frame_px[i].y > r.mxy) r.mxy = frame_px[i].y;
                end
            end
            r.cnt = (n > CNT_MAX) ? CNT_MAX : n;
            if (n > 0) exp_q.push_back(r);
        end
        begin
            exp_t d;
            d.done = 1; d.lab = 0; d.mnx = 0; d.mxx = 0; d.mny = 0; d.mxy = 0; d.cnt = 0;
            exp_q.push_back(d);
        end
        frame_px.delete();
    endtask

    task automatic pix(input bit e, input bit h, input bit v, input logic [7:0] l);
        px_t p;
        en = e; hsync = h; vsync = v; label = l;
        @(negedge clk);
        chk("dropped", dropped, longint'(in_dump && e && l != 0));
        chk("busy", busy, longint'(in_dump));
        if (!in_dump && e && !h && !v && l != 0) begin
            p.x = mx; p.y = my; p.lab = int'(l);
            frame_px.push_back(p);
        end
        if (v) begin
            mx = 0; my = 0;
        end else if (h) begin
            mx = 0;
            if (my < XY_MAX) my++;
        end else if (e && mx < XY_MAX) begin
            mx++;
        end
        @(posedge clk);
        #1;
        if (v && !in_dump) begin
            build_expected();
            vs_cyc = cyc_cnt;
            in_dump = 1;
        end
    endtask

    task automatic idle();
        en = 0; hsync = 0; vsync = 0; label = '0;
    endtask

    task automatic wait_drained(input int budget);
        int n;
        idle();
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_pending", exp_q.size(), 0);
        exp_q.delete();
        in_dump = 0;
    endtask

    task automatic wait_valid(output bit found);
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (out_valid) found = 1;
        end
    endtask

    function automatic logic [7:0] pick_label();
        case ($urandom_range(0, 4))
            0:       return 8'd0;
            1:       return 8'd1;
            2:       return 8'd200;
            3:       return 8'd255;
            default: return 8'($urandom_range(1, 254));
        endcase
    endfunction

    initial begin
        bit found;
        #700000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        idle();
        s_en = 0; s_vsync = 0; s_label = '0;
        reset = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dropped", dropped, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_out_count", out_count, 0);
        chk("rst_out_label", out_label, 0);
        reset = 0;
        @(posedge clk);
        #1;

        // Saturating count on the narrow instance: 19 pixels into a 4-bit counter.
        for (int i = 0; i < 19; i++) begin
            s_en = 1; s_label = 2'd1;
            @(posedge clk);
            #1;
        end
        s_en = 0; s_label = '0; s_vsync = 1;
        @(posedge clk);
        #1;
        s_vsync = 0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (s_valid) begin
                found = 1;
                chk("sat_label", s_out_label, 1);
                chk("sat_count", s_count, 15);
                chk("sat_min_x", s_min_x, 0);
                chk("sat_max_x", s_max_x, 18);
                chk("sat_max_y", s_max_y, 0);
            end
        end
        chk("sat_rec_seen", found, 1);
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (s_done) found = 1;
        end
        chk("sat_done_seen", found, 1);
        @(posedge clk);
        #1;

        // Label 3 at (2,0),(5,0),(1,1).
        pix(1, 0, 0, 0); pix(1, 0, 0, 0); pix(1, 0, 0, 3);
        pix(1, 0, 0, 0); pix(1, 0, 0, 0); pix(1, 0, 0, 3);
        pix(0, 1, 0, 0); pix(1, 0, 0, 0); pix(1, 0, 0, 3);
        pix(0, 0, 1, 0);
        wait_drained(2000);

        // Stalled record must hold for 10 cycles.
        rdy_mode = 2;
        pix(1, 0, 0, 2); pix(1, 0, 0, 0); pix(1, 0, 0, 7);
        pix(0, 0, 1, 0);
        wait_valid(found);
        chk("stall_valid_seen", found, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_hold_valid", out_valid, 1);
            chk("stall_hold_label", out_label, 2);
        end
        rdy_mode = 0;
        wait_drained(2000);

        // Background-only frame: no records, fixed dump length.
        for (int i = 0; i < 20; i++) pix(1, 0, 0, 0);
        pix(0, 1, 0, 0);
        pix(1, 0, 0, 0);
        pix(0, 0, 1, 0);
        wait_drained(2000);
        chk("bg_dump_cycles", done_cyc - vs_cyc, 255);

        // Label 5 pixels offered during the dump are dropped and never counted.
        pix(1, 0, 0, 5); pix(1, 0, 0, 5);
        pix(0, 0, 1, 0);
        pix(1, 0, 0, 5); pix(1, 0, 0, 5); pix(0, 0, 1, 0); pix(1, 0, 0, 5);
        wait_drained(2000);
        pix(1, 0, 0, 0); pix(1, 0, 0, 5); pix(0, 0, 1, 0);
        wait_drained(2000);

        // Reset while a record is stalled.
        rdy_mode = 2;
        pix(1, 0, 0, 4); pix(0, 1, 0, 0); pix(1, 0, 0, 0); pix(1, 0, 0, 4);
        pix(0, 0, 1, 0);
        wait_valid(found);
        chk("rst_stall_valid_seen", found, 1);
        @(posedge clk);
        #1;
        reset = 1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_out_count", out_count, 0);
        exp_q.delete();
        frame_px.delete();
        in_dump = 0; mx = 0; my = 0;
        @(posedge clk);
        #1;
        reset = 0;
        rdy_mode = 0;
        pix(1, 0, 0, 0); pix(1, 0, 0, 0); pix(1, 0, 0, 4); pix(0, 0, 1, 0);
        wait_drained(2000);

        // Randomized frames with random back-pressure and in-dump traffic.
        rdy_mode = 1;
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < 150; i++) begin
                int r;
                r = $urandom_range(0, 99);
                if (r < 5) pix(0, 1, 0, 0);
                else if (r < 85) pix(1, 0, 0, pick_label());
                else pix(0, 0, 0, pick_label());
            end
            pix(0, 0, 1, 0);
            for (int k = 0; k < 4; k++) pix(1'($urandom_range(0, 1)), 0, 1'(k == 2), pick_label());
            wait_drained(3000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
